// File: rtl/fp32_link_pkg.sv
// Shared definitions for the float32 serial link: frame geometry, line levels
// and the transmitter state encoding.
package fp32_link_pkg;

    localparam int   FRAME_BITS = 35;
    localparam int   DATA_BITS  = 32;
    localparam logic START_LVL  = 1'b0;
    localparam logic STOP_LVL   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/fp32_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; push is ignored when
// full and pop is ignored when empty.
module fp32_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fp32_frame_serializer.sv
// Buffers float32 words and transmits each as start, 32 data bits MSB first,
// even parity and stop on a registered, idle-high serial line.
module fp32_frame_serializer #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       frame_count
);

    import fp32_link_pkg::*;

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Handshake: a word transfers on every rising edge where in_valid and
    // in_ready are both high; in_ready depends only on the FIFO being full.
    state_t               state;
    logic [DIV_W-1:0]     div;
    logic [4:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] head;
    logic                 parity;
    logic                 pending;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 bit_end;

    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign bit_end  = (div == DIV_W'(CLKS_PER_BIT - 1));
    // pending delays the idle start by one cycle after the first word lands.
    assign pop      = ((state == IDLE) & pending & ~empty) |
                      ((state == STOP) & bit_end & ~empty);

    fp32_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            parity      <= 1'b0;
            pending     <= 1'b0;
            tx          <= STOP_LVL;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            pending <= ~empty;
            if (state == IDLE || bit_end) div <= '0;
            else                          div <= div + 1'b1;

            case (state)
                IDLE: begin
                    tx <= STOP_LVL;
                    if (pop) begin
                        shreg  <= head;
                        parity <= ^head;
                        tx     <= START_LVL;
                        busy   <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        tx      <= shreg[DATA_BITS-1];
                        shreg   <= {shreg[DATA_BITS-2:0], 1'b0};
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 5'(DATA_BITS - 1)) begin
                            tx    <= parity;
                            state <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[DATA_BITS-1];
                            shreg   <= {shreg[DATA_BITS-2:0], 1'b0};
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx    <= STOP_LVL;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        frame_count <= frame_count + 1'b1;
                        if (pop) begin
                            shreg  <= head;
                            parity <= ^head;
                            tx     <= START_LVL;
                            state  <= START;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= STOP_LVL;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
